// File: rtl/mem_ddr4_ch_seq.sv
// -----------------------------------------------------------------------------
// mem_ddr4_ch_seq
// Per-channel DDR4 power-up sequencer with alert_n filtering and error counting.
// Each channel runs its own IDLE -> RST -> CKE_WAIT -> RUN sequence. While the
// channel is in RUN, its alert_n pin is synchronized and debounced. Every
// qualified low run is counted in a saturating per-channel counter and also
// sets a sticky flag.
//
// Ports
//   clk           single clock for all logic
//   rst           synchronous, active-high reset
//   ch_en         per-channel power-up request (level)
//   alert_n_in    per-channel asynchronous DDR4 alert_n, active-low
//   err_clr       per-channel single-cycle clear of alert_cnt / alert_sticky
//   ddr_reset_n   per-channel DDR4 reset_n drive
//   ddr_cke       per-channel DDR4 cke drive
//   ch_ready      per-channel "in RUN" indication
//   alert_sticky  per-channel flag: an alert event occurred since last clear
//   alert_cnt     packed per-channel counters, channel i at [i*CNT_W +: CNT_W]
//   alert_irq     registered OR of all alert_sticky bits
// -----------------------------------------------------------------------------
module mem_ddr4_ch_seq #(
   parameter int NUM_CH    = 4,
   parameter int RST_CYC   = 200,
   parameter int CKE_CYC   = 500,
   parameter int MIN_ALERT = 2,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic [NUM_CH-1:0]         alert_n_in,
   input  logic [NUM_CH-1:0]         err_clr,
   output logic [NUM_CH-1:0]         ddr_reset_n,
   output logic [NUM_CH-1:0]         ddr_cke,
   output logic [NUM_CH-1:0]         ch_ready,
   output logic [NUM_CH-1:0]         alert_sticky,
   output logic [NUM_CH*CNT_W-1:0]   alert_cnt,
   output logic                      alert_irq
);

   // The sequencing counter must reach the larger of the two wait lengths.
   localparam int CYC_MAX = (RST_CYC > CKE_CYC) ? RST_CYC : CKE_CYC;
   localparam int CW      = $clog2(CYC_MAX + 1);
   localparam int LW      = $clog2(MIN_ALERT + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RST      = 2'd1,
      CKE_WAIT = 2'd2,
      RUN      = 2'd3
   } state_t;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t           state;
      logic [CW-1:0]    cyc_cnt;
      logic             rst_n_q;
      logic             run_q;
      logic [1:0]       sync;
      logic             alert_s;
      logic [LW-1:0]    low_cnt;
      logic             in_run;
      logic             evt;
      logic [CNT_W-1:0] cnt;
      logic             sticky;

      // ---------------------------------------------------------------------
      // Sequencer. The outputs are registered decodes of the current state, so
      // they rise one edge after the state changes. Dropping ch_en clears them
      // on the same edge that forces IDLE, so the pins shut off at once.
      // ---------------------------------------------------------------------
      // NOTE: state registers use non-blocking assignment only, so every block
      // samples the pre-edge value of every other register.
      always_ff @(posedge clk) begin
         if (rst || !ch_en[i]) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            rst_n_q <= 1'b0;
            run_q   <= 1'b0;
         end else begin
            rst_n_q <= (state == CKE_WAIT) || (state == RUN);
            run_q   <= (state == RUN);
            case (state)
               IDLE: begin
                  state   <= RST;
                  cyc_cnt <= '0;
               end
               RST: begin
                  if (cyc_cnt == CW'(RST_CYC - 1)) begin
                     state   <= CKE_WAIT;
                     cyc_cnt <= '0;
                  end else begin
                     cyc_cnt <= cyc_cnt + 1'b1;
                  end
               end
               CKE_WAIT: begin
                  if (cyc_cnt == CW'(CKE_CYC - 1)) begin
                     state   <= RUN;
                     cyc_cnt <= '0;
                  end else begin
                     cyc_cnt <= cyc_cnt + 1'b1;
                  end
               end
               RUN:     cyc_cnt <= '0;
               default: state   <= IDLE;
            endcase
         end
      end

      // ---------------------------------------------------------------------
      // Alert path: 2-flop synchronizer, then a low-run counter that only
      // advances in RUN. The counter holds at MIN_ALERT, so a level that stays
      // low produces a single event until alert_n goes high again.
      // ---------------------------------------------------------------------
      always_ff @(posedge clk) begin
         if (rst) sync <= 2'b11;
         else     sync <= {sync[0], alert_n_in[i]};
      end

      assign alert_s = sync[1];
      assign in_run  = (state == RUN);
      assign evt     = in_run && !alert_s && (low_cnt == LW'(MIN_ALERT - 1));

      always_ff @(posedge clk) begin
         if (rst || !in_run || alert_s) begin
            low_cnt <= '0;
         end else if (low_cnt != LW'(MIN_ALERT)) begin
            low_cnt <= low_cnt + 1'b1;
         end
      end

      // A clear that lands in the same cycle as an event keeps that event.
      // This state survives sequencer exit; only rst or err_clr clears it.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt    <= '0;
            sticky <= 1'b0;
         end else if (err_clr[i]) begin
            cnt    <= evt ? CNT_W'(1) : '0;
            sticky <= evt;
         end else if (evt) begin
            if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
            sticky <= 1'b1;
         end
      end

      assign ddr_reset_n[i]                = rst_n_q;
      assign ddr_cke[i]                    = run_q;
      assign ch_ready[i]                   = run_q;
      assign alert_sticky[i]               = sticky;
      assign alert_cnt[i*CNT_W +: CNT_W]   = cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) alert_irq <= 1'b0;
      else     alert_irq <= |alert_sticky;
   end

endmodule

// File: tb/tb_mem_ddr4_ch_seq.sv
module tb_mem_ddr4_ch_seq;

   localparam int NUM_CH    = 2;
   localparam int RST_CYC   = 4;
   localparam int CKE_CYC   = 3;
   localparam int MIN_ALERT = 2;
   localparam int CNT_W     = 4;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       ch_en;
   logic [NUM_CH-1:0]       alert_n_in;
   logic [NUM_CH-1:0]       err_clr;
   logic [NUM_CH-1:0]       ddr_reset_n;
   logic [NUM_CH-1:0]       ddr_cke;
   logic [NUM_CH-1:0]       ch_ready;
   logic [NUM_CH-1:0]       alert_sticky;
   logic [NUM_CH*CNT_W-1:0] alert_cnt;
   logic                    alert_irq;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   mem_ddr4_ch_seq #(
      .NUM_CH    (NUM_CH),
      .RST_CYC   (RST_CYC),
      .CKE_CYC   (CKE_CYC),
      .MIN_ALERT (MIN_ALERT),
      .CNT_W     (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ch_en        (ch_en),
      .alert_n_in   (alert_n_in),
      .err_clr      (err_clr),
      .ddr_reset_n  (ddr_reset_n),
      .ddr_cke      (ddr_cke),
      .ch_ready     (ch_ready),
      .alert_sticky (alert_sticky),
      .alert_cnt    (alert_cnt),
      .alert_irq    (alert_irq)
   );

   always #5 clk = ~clk;

   // Edge number n means the n-th rising edge since time zero.
   always @(posedge clk) cyc <= cyc + 1;

   // Return 1 time unit after edge n: outputs settled, inputs driven here are
   // sampled at edge n+1.
   task automatic go_to(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at edge %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst        = 1'b1;
      ch_en      = '0;
      alert_n_in = '1;
      err_clr    = '0;

      // Reset state
      go_to(3);
      check("rst_reset_n", ddr_reset_n, 0);
      check("rst_cke", ddr_cke, 0);
      check("rst_ready", ch_ready, 0);
      check("rst_cnt", alert_cnt, 0);
      check("rst_sticky", alert_sticky, 0);
      check("rst_irq", alert_irq, 0);
      rst = 1'b0;

      // Power-up of channel 0: ch_en sampled high at edge 10
      go_to(9);  ch_en = 2'b01;
      go_to(14); check("pu_reset_n_early", ddr_reset_n, 2'b00);
      go_to(15); check("pu_reset_n_rise", ddr_reset_n, 2'b01);
      go_to(17); check("pu_cke_early", ddr_cke, 2'b00);
      check("pu_ready_early", ch_ready, 2'b00);
      go_to(18); check("pu_cke_rise", ddr_cke, 2'b01);
      check("pu_ready_rise", ch_ready, 2'b01);
      check("pu_reset_n_hold", ddr_reset_n, 2'b01);

      // One-cycle glitch is filtered
      go_to(20); alert_n_in = 2'b10;
      go_to(21); alert_n_in = 2'b11;
      go_to(26); check("glitch_cnt", alert_cnt, 0);
      check("glitch_sticky", alert_sticky, 0);

      // Five-cycle low pulse: event at edge 34, irq one edge later
      go_to(30); alert_n_in = 2'b10;
      go_to(33); check("pulse_cnt_before", alert_cnt, 0);
      go_to(34); check("pulse_cnt", alert_cnt, 8'h01);
      check("pulse_sticky", alert_sticky, 2'b01);
      check("pulse_irq_lag", alert_irq, 0);
      go_to(35); alert_n_in = 2'b11;
      check("pulse_irq", alert_irq, 1);
      go_to(40); check("pulse_single_event", alert_cnt, 8'h01);

      // err_clr alone
      err_clr = 2'b01;
      go_to(41); err_clr = 2'b00;
      check("clr_cnt", alert_cnt, 0);
      check("clr_sticky", alert_sticky, 0);
      go_to(42); check("clr_irq", alert_irq, 0);

      // 17 events saturate a 4-bit counter at 15
      for (int j = 0; j < 17; j++) begin
         go_to(50 + j*6);     alert_n_in = 2'b10;
         go_to(50 + j*6 + 3); alert_n_in = 2'b11;
      end
      go_to(155); check("sat_cnt", alert_cnt, 8'h0F);
      check("sat_sticky", alert_sticky, 2'b01);

      // err_clr coincident with the 18th event (event at edge 164)
      go_to(160); alert_n_in = 2'b10;
      go_to(163); alert_n_in = 2'b11; err_clr = 2'b01;
      check("clr_evt_before", alert_cnt, 8'h0F);
      go_to(164); err_clr = 2'b00;
      check("clr_evt_cnt", alert_cnt, 8'h01);
      check("clr_evt_sticky", alert_sticky, 2'b01);

      // Leaving RUN turns pins off at once; counter and flag survive
      go_to(169); ch_en = 2'b00;
      go_to(170); check("exit_ready", ch_ready, 0);
      check("exit_cke", ddr_cke, 0);
      check("exit_reset_n", ddr_reset_n, 0);
      check("exit_cnt_kept", alert_cnt, 8'h01);
      check("exit_sticky_kept", alert_sticky, 2'b01);

      // Abort in RST, then restart from scratch
      go_to(179); ch_en = 2'b01;
      go_to(183); ch_en = 2'b00;
      go_to(188); check("abort_idle", ddr_reset_n, 2'b00);
      go_to(189); ch_en = 2'b01;
      go_to(194); check("restart_reset_n_early", ddr_reset_n, 2'b00);
      go_to(195); check("restart_reset_n_rise", ddr_reset_n, 2'b01);

      // Channel 1: alert low during CKE_WAIT and across RUN entry (RUN at 207)
      go_to(199); ch_en = 2'b11;
      go_to(204); alert_n_in = 2'b01;
      go_to(206); check("cke_wait_no_evt", alert_cnt, 8'h01);
      go_to(208); check("run_entry_ready", ch_ready, 2'b11);
      check("run_entry_no_evt", alert_cnt, 8'h01);
      go_to(209); check("run_entry_evt", alert_cnt, 8'h11);
      check("run_entry_sticky", alert_sticky, 2'b11);
      go_to(215); check("held_low_one_evt", alert_cnt, 8'h11);
      alert_n_in = 2'b11;

      // Both channels to count 3, then reset in RUN
      go_to(216); err_clr = 2'b11;
      go_to(217); err_clr = 2'b00;
      check("clr_both", alert_cnt, 0);
      for (int j = 0; j < 3; j++) begin
         go_to(220 + j*6);     alert_n_in = 2'b00;
         go_to(220 + j*6 + 3); alert_n_in = 2'b11;
      end
      go_to(240); check("pre_rst_cnt", alert_cnt, 8'h33);
      check("pre_rst_irq", alert_irq, 1);
      rst = 1'b1;
      go_to(241); check("mid_rst_reset_n", ddr_reset_n, 0);
      check("mid_rst_cke", ddr_cke, 0);
      check("mid_rst_ready", ch_ready, 0);
      check("mid_rst_cnt", alert_cnt, 0);
      check("mid_rst_sticky", alert_sticky, 0);
      check("mid_rst_irq", alert_irq, 0);

      // ch_en held high through reset: sequence starts at edge 244
      go_to(243); rst = 1'b0;
      go_to(248); check("post_rst_reset_n_early", ddr_reset_n, 2'b00);
      go_to(249); check("post_rst_reset_n_rise", ddr_reset_n, 2'b11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
